// File: rtl/delta_to_index_if.sv
// Delta token stream in, absolute coordinate stream out.
// master = producer/consumer side, slave = converter side.
interface delta_to_index_if #(
    parameter int INDEX_WIDTH = 32
);
    logic                   delta_push;
    logic [1:0]             delta_type;
    logic [INDEX_WIDTH-1:0] delta_value;
    logic                   delta_stall;
    logic                   push_index;
    logic [INDEX_WIDTH-1:0] row;
    logic [INDEX_WIDTH-1:0] col;
    logic                   stall_index;

    modport master (
        output delta_push,
        output delta_type,
        output delta_value,
        output stall_index,
        input  delta_stall,
        input  push_index,
        input  row,
        input  col
    );

    modport slave (
        input  delta_push,
        input  delta_type,
        input  delta_value,
        input  stall_index,
        output delta_stall,
        output push_index,
        output row,
        output col
    );
endinterface

// File: rtl/delta_to_index.sv
// Accumulates row/col deltas into absolute coordinates,
// buffers them in a small FIFO and flags end-of-matrix.
module delta_to_index #(
    parameter int INDEX_WIDTH     = 32,
    parameter int LOG2_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    delta_to_index_if.slave       bus,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           nnz_count
);
    localparam int W     = INDEX_WIDTH;
    localparam int PW    = LOG2_FIFO_DEPTH;
    localparam int CW    = LOG2_FIFO_DEPTH + 1;
    localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN  = CW'(2);

    localparam logic [1:0] T_COL = 2'd0;
    localparam logic [1:0] T_ROW = 2'd1;
    localparam logic [1:0] T_END = 2'd2;
    localparam logic [1:0] T_RSV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    row_q, row_d;
    logic [W-1:0]    col_q, col_d;
    logic            err_q, err_d;
    logic [31:0]     nnz_q, nnz_d;
    logic            stall_q, stall_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  mem_q [DEPTH];

    logic            start_acc;
    logic            accept;
    logic            end_tok;
    logic            wr_en;
    logic            wr_ok;
    logic            pop;
    logic [W:0]      col_sum;
    logic [W:0]      row_sum;
    logic [CW-1:0]   free_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: END moves to drain, drain ends once the FIFO is empty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (end_tok) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start only counts when no matrix is in flight.
    always_comb begin
        start_acc = start &&
                    (state_q == S_IDLE || state_q == S_DONE);
        accept    = (state_q == S_RUN) && bus.delta_push;
        end_tok   = accept && (bus.delta_type == T_END);
        done      = (state_q == S_DONE);
    end

    // Accumulators; carry-out of either sum is sticky in error.
    always_comb begin
        col_sum = {1'b0, col_q} + {1'b0, bus.delta_value};
        row_sum = {1'b0, row_q} + {1'b0, bus.delta_value};
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        if (start_acc) begin
            row_d = '0;
            col_d = '0;
            err_d = 1'b0;
        end else if (accept) begin
            unique case (bus.delta_type)
                T_COL: begin
                    col_d = col_sum[W-1:0];
                    err_d = err_q | col_sum[W];
                    wr_en = 1'b1;
                end
                T_ROW: begin
                    row_d = row_sum[W-1:0];
                    col_d = '0;
                    err_d = err_q | row_sum[W];
                end
                T_END: ;
                T_RSV: err_d = 1'b1;
            endcase
        end
    end

    // FIFO bookkeeping and registered producer backpressure.
    always_comb begin
        pop    = (cnt_q != '0) && !bus.stall_index;
        wr_ok  = wr_en && ((cnt_q != DEPTH_C) || pop);
        wptr_d = wr_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (wr_ok && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!wr_ok && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
        free_d  = DEPTH_C - cnt_d;
        stall_d = !((state_d == S_RUN) && (free_d >= MARGIN));
        nnz_d   = start_acc ? 32'd0 : nnz_q + 32'(pop);
    end

    // Control and accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            nnz_q   <= '0;
            stall_q <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            nnz_q   <= nnz_d;
            stall_q <= stall_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= {row_q, col_sum[W-1:0]};
        end
    end

    assign bus.delta_stall = stall_q;
    assign bus.push_index  = pop;
    assign bus.row         = mem_q[rptr_q][2*W-1:W];
    assign bus.col         = mem_q[rptr_q][W-1:0];
    assign error           = err_q;
    assign nnz_count       = nnz_q;
endmodule

// File: tb/tb_delta_to_index.sv
// Bench for delta_to_index: directed scenarios plus random
// matrices checked against a coordinate-list reference model.
module tb_delta_to_index;
    localparam int W = 32;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        error;
    logic [31:0] nnz_count;

    delta_to_index_if #(.INDEX_WIDTH(W)) bus();

    delta_to_index #(
        .INDEX_WIDTH(W),
        .LOG2_FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .done(done),
        .error(error),
        .nnz_count(nnz_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint unsigned m_row;
    longint unsigned m_col;
    bit              m_err;
    int              m_phase;
    logic [63:0]     exp_q[$];
    logic [63:0]     got_q[$];

    // Record every coordinate handed to the consumer.
    always @(negedge clk) begin
        if (rst && bus.push_index) got_q.push_back({bus.row, bus.col});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one token and apply the matrix rules to the model.
    task automatic drive(input logic [1:0] t, input logic [31:0] v);
        longint unsigned s;
        bus.delta_push  = 1'b1;
        bus.delta_type  = t;
        bus.delta_value = v;
        if (m_phase == 1) begin
            case (t)
                2'd0: begin
                    s = m_col + longint'(v);
                    if (s >= MOD) m_err = 1'b1;
                    m_col = s % MOD;
                    exp_q.push_back({m_row[31:0], m_col[31:0]});
                end
                2'd1: begin
                    s = m_row + longint'(v);
                    if (s >= MOD) m_err = 1'b1;
                    m_row = s % MOD;
                    m_col = 0;
                end
                2'd2: m_phase = 2;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] v);
        drive(t, v);
        tick();
        bus.delta_push = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        if (m_phase == 0) begin
            m_phase = 1;
            m_row = 0;
            m_col = 0;
            m_err = 1'b0;
            exp_q.delete();
            got_q.delete();
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) m_phase = 0;
    endtask

    task automatic test_reset;
        bus.delta_push  = 1'b0;
        bus.delta_type  = 2'd0;
        bus.delta_value = '0;
        bus.stall_index = 1'b0;
        m_phase = 0;
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.push_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_push: got %b required 0", bus.push_index);
        end
        checks++;
        if (bus.delta_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b required 1", bus.delta_stall);
        end
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b error=%b required 0 0",
                     done, error);
        end
        checks++;
        if (nnz_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_nnz: got %0d required 0", nnz_count);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        bit ok;
        logic [63:0] want [3];
        want[0] = {32'd3, 32'd5};
        want[1] = {32'd3, 32'd7};
        want[2] = {32'd4, 32'd0};
        do_start();
        send(2'd1, 3);
        send(2'd0, 5);
        send(2'd0, 2);
        send(2'd1, 1);
        send(2'd0, 0);
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done: got done=0 required 1");
        end
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL basic_count: got %0d required 3", got_q.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL basic_coord[%0d]: got %h required %h",
                             i, got_q[i], want[i]);
                end
            end
        end
        checks++;
        if (nnz_count !== 32'd3 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got nnz=%0d err=%b required 3 0",
                     nnz_count, error);
        end
        checks++;
        if (bus.delta_stall !== 1'b1) begin
            errors++;
            $display("FAIL done_stall: got %b required 1", bus.delta_stall);
        end
    endtask

    task automatic test_latency;
        bit ok;
        do_start();
        drive(2'd0, 9);
        tick();
        bus.delta_push = 1'b0;
        checks++;
        if (bus.push_index !== 1'b1 || bus.row !== 32'd0 ||
            bus.col !== 32'd9) begin
            errors++;
            $display("FAIL latency: got push=%b (%0d,%0d) required 1 (0,9)",
                     bus.push_index, bus.row, bus.col);
        end
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || nnz_count !== 32'd1) begin
            errors++;
            $display("FAIL latency_end: got done=%b nnz=%0d required 1 1",
                     ok, nnz_count);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        bit cur;
        bit prev;
        int n;
        do_start();
        bus.stall_index = 1'b1;
        prev = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cur = bus.delta_stall;
            if (!cur || !prev) begin
                drive(2'd0, 1);
                n++;
            end else begin
                bus.delta_push = 1'b0;
            end
            prev = cur;
            tick();
        end
        bus.delta_push = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_pushes: got %0d required 4", n);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.push_index !== 1'b0 || bus.row !== 32'd0 ||
                bus.col !== 32'd1 || bus.delta_stall !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got push=%b (%0d,%0d) stall=%b required 0 (0,1) 1",
                         bus.push_index, bus.row, bus.col, bus.delta_stall);
            end
            tick();
        end
        bus.stall_index = 1'b0;
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d required %0d",
                     got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_coord[%0d]: got %h required %h",
                             i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_wrap;
        bit ok;
        logic [63:0] want [2];
        want[0] = {32'd0, 32'hFFFF_FFFF};
        want[1] = {32'd0, 32'd1};
        do_start();
        send(2'd0, 32'hFFFF_FFFF);
        send(2'd0, 2);
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d required 2", got_q.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL wrap_coord[%0d]: got %h required %h",
                             i, got_q[i], want[i]);
                end
            end
        end
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL wrap_error: got %b required 1", error);
        end
    endtask

    task automatic test_reserved;
        bit ok;
        send(2'd0, 5);
        tick();
        checks++;
        if (bus.push_index !== 1'b0) begin
            errors++;
            $display("FAIL idle_drop: got push=%b required 0", bus.push_index);
        end
        do_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL start_clear_err: got %b required 0", error);
        end
        send(2'd3, 7);
        tick();
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL rsv_error: got %b required 1", error);
        end
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || got_q.size() != 0 || nnz_count !== 32'd0) begin
            errors++;
            $display("FAIL rsv_output: got %0d pushes nnz=%0d required 0 0",
                     got_q.size(), nnz_count);
        end
    endtask

    task automatic test_async_reset;
        bit ok;
        logic [63:0] want [2];
        want[0] = {32'd0, 32'd3};
        want[1] = {32'd2, 32'd1};
        do_start();
        bus.stall_index = 1'b1;
        send(2'd0, 1);
        send(2'd0, 2);
        send(2'd2, 0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.push_index !== 1'b0 || bus.delta_stall !== 1'b1 ||
            done !== 1'b0 || nnz_count !== 32'd0) begin
            errors++;
            $display("FAIL arst: got push=%b stall=%b done=%b nnz=%0d required 0 1 0 0",
                     bus.push_index, bus.delta_stall, done, nnz_count);
        end
        m_phase = 0;
        exp_q.delete();
        got_q.delete();
        bus.stall_index = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.push_index !== 1'b0) begin
            errors++;
            $display("FAIL arst_flush: got push=%b required 0", bus.push_index);
        end
        do_start();
        send(2'd0, 3);
        send(2'd1, 2);
        send(2'd0, 1);
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++;
            $display("FAIL arst_count: got %0d required 2", got_q.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL arst_coord[%0d]: got %h required %h",
                             i, got_q[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_start_in_run;
        bit ok;
        logic [63:0] want [2];
        want[0] = {32'd2, 32'd4};
        want[1] = {32'd2, 32'd5};
        do_start();
        send(2'd1, 2);
        send(2'd0, 4);
        do_start();
        send(2'd0, 1);
        send(2'd2, 0);
        wait_done(ok);
        checks++;
        if (!ok || got_q.size() != 2) begin
            errors++;
            $display("FAIL sir_count: got %0d required 2", got_q.size());
        end else begin
            foreach (want[i]) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL sir_coord[%0d]: got %h required %h",
                             i, got_q[i], want[i]);
                end
            end
        end
        checks++;
        if (nnz_count !== 32'd2) begin
            errors++;
            $display("FAIL sir_nnz: got %0d required 2", nnz_count);
        end
    endtask

    task automatic test_random;
        bit ok;
        bit cur;
        bit prev;
        int n;
        int sent;
        int r;
        logic [1:0]  t;
        logic [31:0] v;
        for (int m = 0; m < 8; m++) begin
            do_start();
            n = $urandom_range(5, 30);
            sent = 0;
            prev = 1'b0;
            for (int c = 0; c < 2000 && sent <= n; c++) begin
                cur = bus.delta_stall;
                bus.stall_index = ($urandom_range(0, 2) == 0);
                if ((!cur || !prev) && $urandom_range(0, 3) != 0) begin
                    r = $urandom_range(0, 19);
                    t = (r < 12) ? 2'd0 : (r < 19) ? 2'd1 : 2'd3;
                    if (sent == n) t = 2'd2;
                    v = ($urandom_range(0, 7) == 0) ? $urandom
                                                    : $urandom_range(0, 20);
                    drive(t, v);
                    sent++;
                end else begin
                    bus.delta_push = 1'b0;
                end
                prev = cur;
                tick();
            end
            bus.delta_push = 1'b0;
            bus.stall_index = 1'b0;
            wait_done(ok);
            checks++;
            if (!ok || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d required %0d (done=%b)",
                         m, got_q.size(), exp_q.size(), ok);
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_coord[%0d]: got %h required %h",
                                 m, i, got_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (error !== m_err || nnz_count !== 32'(exp_q.size())) begin
                errors++;
                $display("FAIL rand%0d_status: got err=%b nnz=%0d required %b %0d",
                         m, error, nnz_count, m_err, exp_q.size());
            end
            m_phase = 0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_wrap();
        test_reserved();
        test_async_reset();
        test_start_in_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
